// File: rtl/id_stage_pipe_if.sv
// Decode-to-execute channel: one registered decoded entry under a valid/ready handshake.
// The decode stage drives the entry (master); the execute stage returns out_ready (slave).
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int AOP_W  = 8,
  parameter int ASEL_W = 3
) ();
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       pc_o;
  logic [AOP_W-1:0]  aluop_o;
  logic [ASEL_W-1:0] alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;
  logic              inst_invalid_o;

  modport master (
    output out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o,
    input  out_ready
  );

  modport slave (
    input  out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o,
    output out_ready
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS decode stage for logic-class instructions: register read, multi-source forwarding,
// load-use stall and a single-entry valid/ready output register toward EX.
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int AOP_W   = 8,
  parameter int ASEL_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic [ADDR_W-1:0]         reg1_addr_o,
  output logic [ADDR_W-1:0]         reg2_addr_o,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic                      flush_i,
  id_stage_pipe_if.master           ex_if,
  output logic [15:0]               stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;

  localparam logic [AOP_W-1:0]  NOP_OP    = '0;
  localparam logic [AOP_W-1:0]  AND_OP    = AOP_W'(8'b00100100);
  localparam logic [AOP_W-1:0]  OR_OP     = AOP_W'(8'b00100101);
  localparam logic [AOP_W-1:0]  XOR_OP    = AOP_W'(8'b00100110);
  localparam logic [AOP_W-1:0]  NOR_OP    = AOP_W'(8'b00100111);
  localparam logic [ASEL_W-1:0] SEL_LOGIC = ASEL_W'(3'b001);

  typedef struct packed {
    logic [31:0]       pc;
    logic [AOP_W-1:0]  aluop;
    logic [ASEL_W-1:0] alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic              invalid;
  } entry_t;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic              re1;
  logic              re2;
  logic              r_type_hit;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   opnd1;
  logic [DATA_W:0]   opnd2;
  logic              hazard;
  logic              accept;
  entry_t            entry_d, entry_q;
  logic              out_valid_d, out_valid_q;
  logic [15:0]       stall_cnt_d, stall_cnt_q;
  logic              unused_shamt;

  assign op           = inst_i[31:26];
  assign funct        = inst_i[5:0];
  assign unused_shamt = ^inst_i[10:6];

  // Returns {pending, data}. Scanning from oldest to youngest lets the youngest match win.
  function automatic logic [DATA_W:0] sel_operand(
    input logic                      re,
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [DATA_W-1:0]         imm_val,
    input logic [NUM_FWD-1:0]        wreg,
    input logic [NUM_FWD-1:0]        pend,
    input logic [NUM_FWD*ADDR_W-1:0] wd,
    input logic [NUM_FWD*DATA_W-1:0] wdata
  );
    logic [DATA_W:0] r;
    r = {1'b0, rf_data};
    if (!re) begin
      r = {1'b0, imm_val};
    end else if (addr == '0) begin
      r = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (wreg[i] && (wd[i*ADDR_W +: ADDR_W] == addr)) begin
          r = {pend[i], wdata[i*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    re1                = 1'b0;
    re2                = 1'b0;
    r_type_hit         = 1'b0;
    imm                = '0;
    entry_d            = '0;
    entry_d.pc         = pc_i;
    entry_d.aluop      = NOP_OP;
    entry_d.invalid    = 1'b1;

    case (op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        re1             = 1'b1;
        entry_d.invalid = 1'b0;
        entry_d.wreg    = 1'b1;
        entry_d.alusel  = SEL_LOGIC;
        entry_d.wd      = ADDR_W'(inst_i[20:16]);
        imm             = (op == OP_LUI) ? DATA_W'({inst_i[15:0], 16'h0000})
                                         : DATA_W'({16'h0000, inst_i[15:0]});
        case (op)
          OP_ANDI: entry_d.aluop = AND_OP;
          OP_XORI: entry_d.aluop = XOR_OP;
          default: entry_d.aluop = OR_OP;
        endcase
      end
      OP_SPECIAL: begin
        case (funct)
          FN_OR:   begin entry_d.aluop = OR_OP;  r_type_hit = 1'b1; end
          FN_AND:  begin entry_d.aluop = AND_OP; r_type_hit = 1'b1; end
          FN_XOR:  begin entry_d.aluop = XOR_OP; r_type_hit = 1'b1; end
          FN_NOR:  begin entry_d.aluop = NOR_OP; r_type_hit = 1'b1; end
          default: ;
        endcase
        if (r_type_hit) begin
          re1             = 1'b1;
          re2             = 1'b1;
          entry_d.invalid = 1'b0;
          entry_d.wreg    = 1'b1;
          entry_d.alusel  = SEL_LOGIC;
          entry_d.wd      = ADDR_W'(inst_i[15:11]);
        end
      end
      default: ;
    endcase

    opnd1 = sel_operand(re1, reg1_addr_o, reg1_data_i, imm, fwd_wreg_i, fwd_pending_i,
                        fwd_wd_i, fwd_wdata_i);
    opnd2 = sel_operand(re2, reg2_addr_o, reg2_data_i, imm, fwd_wreg_i, fwd_pending_i,
                        fwd_wd_i, fwd_wdata_i);
    entry_d.reg1 = opnd1[DATA_W-1:0];
    entry_d.reg2 = opnd2[DATA_W-1:0];
  end

  assign reg1_addr_o = ADDR_W'(inst_i[25:21]);
  assign reg2_addr_o = ADDR_W'(inst_i[20:16]);
  assign reg1_read_o = re1;
  assign reg2_read_o = re2;

  assign hazard   = opnd1[DATA_W] | opnd2[DATA_W];
  assign in_ready = !hazard && !flush_i && (!out_valid_q || ex_if.out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (flush_i || ex_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q     <= '0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        entry_q <= entry_d;
      end
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_if.out_valid      = out_valid_q;
  assign ex_if.pc_o           = entry_q.pc;
  assign ex_if.aluop_o        = entry_q.aluop;
  assign ex_if.alusel_o       = entry_q.alusel;
  assign ex_if.reg1_o         = entry_q.reg1;
  assign ex_if.reg2_o         = entry_q.reg2;
  assign ex_if.wd_o           = entry_q.wd;
  assign ex_if.wreg_o         = entry_q.wreg;
  assign ex_if.inst_invalid_o = entry_q.invalid;
  assign stall_cnt_o          = stall_cnt_q;

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered, parametrised instruction-decode stage for the 32-bit MIPS pipeline. It sits between the IF/ID register and EX. It decodes logic-class instructions, reads two register-file ports, and resolves operands through a configurable number of forwarding sources. It stalls on load-use hazards and delivers one decoded entry to EX through a valid/ready output register.

## Interface
Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 5, register address width
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), higher = older (MEM, WB…)
- AOP_W, 8, aluop width
- ASEL_W, 3, alusel width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pc_i/inst_i hold a valid instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- pc_i  in  32  instruction PC
- inst_i  in  32  instruction word
- reg1_addr_o, reg2_addr_o  out  ADDR_W  regfile read addresses = inst_i[25:21], inst_i[20:16] (combinational)
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data
- fwd_wreg_i  in  NUM_FWD  source i writes a register
- fwd_wd_i  in  NUM_FWD*ADDR_W  destination of source i, slice i at [i*ADDR_W +: ADDR_W]
- fwd_wdata_i  in  NUM_FWD*DATA_W  result of source i
- fwd_pending_i  in  NUM_FWD  source i result not yet available (e.g. load in EX)
- flush_i  in  1  discard held entry; block acceptance this cycle
- out_valid  out  1  registered entry valid
- out_ready  in  1  EX consumes entry
- pc_o  out  32  registered PC
- aluop_o  out  AOP_W  registered
- alusel_o  out  ASEL_W  registered
- reg1_o, reg2_o  out  DATA_W  registered operands
- wd_o  out  ADDR_W  registered destination
- wreg_o  out  1  registered write enable
- inst_invalid_o  out  1  registered: opcode not decoded
- stall_cnt_o  out  16  saturating count of hazard-stall cycles

## Operation
- Decode (combinational on inst_i), op = [31:26], funct = [5:0]:
  - ORI 001101 → OR_OP 8'b00100101. ANDI 001100 → AND_OP 8'b00100100. XORI 001110 → XOR_OP 8'b00100110.
  - For these three: reg1 read, imm = {16'h0, inst[15:0]}, wd = inst[20:16].
  - LUI 001111 → OR_OP, reg1 read (rs), imm = {inst[15:0], 16'h0}, wd = inst[20:16].
  - SPECIAL 000000 with funct 100101/100100/100110/100111 → OR/AND/XOR/NOR_OP (NOR 8'b00100111); both ports read; wd = inst[15:11].
  - All decoded instructions: alusel = LOGIC 3'b001, wreg = 1.
  - Anything else: aluop NOP 8'h00, alusel 3'b000, wreg 0, no reads, inst_invalid = 1.
- Operand select, per port with read enable:
  - Address 0 → 0; never forwarded.
  - Otherwise the lowest index i with fwd_wreg_i[i] and matching fwd_wd_i slice wins and supplies fwd_wdata_i; if none matches, the regfile data is used.
  - Port without read enable → imm.
- Hazard: the winning match for either read port has fwd_pending_i[i] = 1. An older non-pending match never overrides a younger pending one.
- in_ready = !hazard && !flush_i && (!out_valid || out_ready).
- Accept (in_valid && in_ready): output register loads decode + operands; out_valid ← 1.
- No accept, out_valid && out_ready: out_valid ← 0. No accept, !out_ready: all outputs hold.
- flush_i: out_valid ← 0 next edge, regardless of out_ready.
- stall_cnt_o increments each cycle in_valid && hazard, saturates at 16'hFFFF, clears only on reset.

## Timing
- Reset: every registered output = 0 (out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o, stall_cnt_o); effective immediately on rst low, independent of clk.
- Latency: instruction accepted at edge N appears at outputs after edge N; one entry per cycle at full throughput (out_ready held 1).
- reg*_addr_o, reg*_read_o, in_ready: same-cycle combinational; no path from out_ready to outputs except in_ready.
- Simultaneous flush_i and in_valid: instruction not accepted; upstream must hold or drop it.
- Simultaneous hazard and out_ready: held entry drains; out_valid falls to 0; stall continues.
- Reset mid-stall: counter and entry cleared; hazard re-evaluated from inputs after release.

## Test plan
- ORI $3,$1,0x00FF, reg1_data_i=0x12340000, no forwarding, out_ready=1 → next cycle out_valid=1, aluop_o=0x25, alusel_o=1, reg1_o=0x12340000, reg2_o=0x000000FF, wd_o=3, wreg_o=1.
- OR $5,$2,$2 with fwd 0 and fwd 1 both writing $2 (0xAAAA0000, 0x5555FFFF) → reg1_o=reg2_o=0xAAAA0000. Same instruction with $0 targeted by fwd → reg1_o=0.
- fwd_pending_i[0]=1 for $2, in_valid held 3 cycles, then pending cleared → in_ready=0 for 3 cycles, stall_cnt_o=3, entry accepted on cycle 4 with forwarded value.
- out_ready=0 with entry held, new in_valid → in_ready=0, outputs unchanged; out_ready=1 → new entry loads next edge.
- Opcode 0x3F → inst_invalid_o=1, aluop_o=0, wreg_o=0. flush_i with out_valid=1 → out_valid=0 next edge.
- Assert rst low mid-stream between edges → all outputs 0 immediately, stall_cnt_o=0.
